// File: rtl/thunderbird_pkg.sv
// Shared definitions for the thunderbird tail-light lamp FSM and its bus decoder.
// Contents: decoder state enum, mode encodings, lamp-bus pattern constants and
// small mapping helpers. Lamp bus bit order: [5:3]={LC,LB,LA}, [2:0]={RA,RB,RC}.
package thunderbird_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_L2   = 3'd2,
    S_L3   = 3'd3,
    S_R1   = 3'd4,
    S_R2   = 3'd5,
    S_R3   = 3'd6,
    S_HZ   = 3'd7
  } state_t;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_LEFT   = 2'd1;
  localparam logic [1:0] MODE_RIGHT  = 2'd2;
  localparam logic [1:0] MODE_HAZARD = 2'd3;

  localparam logic [5:0] PAT_OFF = 6'b000_000;
  localparam logic [5:0] PAT_L1  = 6'b001_000;
  localparam logic [5:0] PAT_L2  = 6'b011_000;
  localparam logic [5:0] PAT_L3  = 6'b111_000;
  localparam logic [5:0] PAT_R1  = 6'b000_100;
  localparam logic [5:0] PAT_R2  = 6'b000_110;
  localparam logic [5:0] PAT_R3  = 6'b000_111;
  localparam logic [5:0] PAT_ALL = 6'b111_111;

  function automatic logic [1:0] state_mode(input state_t s);
    logic [1:0] m;
    case (s)
      S_L1, S_L2, S_L3: m = MODE_LEFT;
      S_R1, S_R2, S_R3: m = MODE_RIGHT;
      S_HZ:             m = MODE_HAZARD;
      default:          m = MODE_IDLE;
    endcase
    return m;
  endfunction

  function automatic logic [1:0] state_step(input state_t s);
    logic [1:0] k;
    case (s)
      S_L1, S_R1, S_HZ: k = 2'd1;
      S_L2, S_R2:       k = 2'd2;
      S_L3, S_R3:       k = 2'd3;
      default:          k = 2'd0;
    endcase
    return k;
  endfunction

  // After an error, a pattern that can start a sequence is taken as that start
  // so the checker locks back on without losing a whole sequence.
  function automatic state_t resync_state(input logic [5:0] pat);
    state_t s;
    case (pat)
      PAT_L1:  s = S_L1;
      PAT_R1:  s = S_R1;
      PAT_ALL: s = S_HZ;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/thunderbird_light_decoder_sat_counter.sv
// Saturating up-counter used for the decoder's error and sequence statistics.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset, clears q
//   inc    increment request, ignored once q is all ones
//   q      count value
module tb_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + ONE;
    end
  end

endmodule

// File: rtl/thunderbird_light_decoder.sv
// Thunderbird tail-light bus decoder / protocol checker.
// Samples the 6-bit lamp bus every clock, tracks left, right and hazard
// sequences, and reports mode, step, completed sequences and protocol errors.
// All outputs are registered (one cycle after the sampling edge).
//
// Optional feature: define THUNDERBIRD_DEC_STAT_EN to build the per-sequence
// completion counters; without it left_cnt/right_cnt/hz_cnt are tied to 0.
//
// Ports:
//   clk        system clock, light_out sampled on posedge
//   reset      asynchronous active-low reset
//   light_out  lamp bus [5:3]={LC,LB,LA}, [2:0]={RA,RB,RC}
//   mode       0=IDLE 1=LEFT 2=RIGHT 3=HAZARD
//   step       position in sequence (1..3 left/right, 1 hazard, 0 idle)
//   seq_done   one-cycle pulse on sequence completion
//   err        one-cycle pulse on illegal pattern or transition
//   err_count  saturating error count
//   left_cnt   completed LEFT sequences
//   right_cnt  completed RIGHT sequences
//   hz_cnt     completed HAZARD sequences
//
// state  | meaning
// S_IDLE | lamps off, waiting for a sequence start
// S_L1   | left sequence, LA lit
// S_L2   | left sequence, LA+LB lit
// S_L3   | left sequence, all left lit, OFF completes it
// S_R1   | right sequence, RA lit
// S_R2   | right sequence, RA+RB lit
// S_R3   | right sequence, all right lit, OFF completes it
// S_HZ   | hazard, all lamps lit, OFF completes it
module thunderbird_light_decoder
  import thunderbird_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       light_out,
  output logic [1:0]       mode,
  output logic [1:0]       step,
  output logic             seq_done,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] left_cnt,
  output logic [CNT_W-1:0] right_cnt,
  output logic [CNT_W-1:0] hz_cnt
);

  state_t state;
  state_t state_nxt;
  logic   hit_err;
  logic   hit_done;

  // Every sampled pattern must advance the sequence, so a held pattern outside
  // idle falls into the error branch naturally.
  always_comb begin
    state_nxt = state;
    hit_err   = 1'b0;
    hit_done  = 1'b0;
    case (state)
      S_IDLE: begin
        case (light_out)
          PAT_OFF: state_nxt = S_IDLE;
          PAT_L1:  state_nxt = S_L1;
          PAT_R1:  state_nxt = S_R1;
          PAT_ALL: state_nxt = S_HZ;
          default: hit_err   = 1'b1;
        endcase
      end
      S_L1: begin
        if (light_out == PAT_L2)       state_nxt = S_L2;
        else if (light_out == PAT_OFF) state_nxt = S_IDLE;
        else                           hit_err   = 1'b1;
      end
      S_L2: begin
        if (light_out == PAT_L3)       state_nxt = S_L3;
        else if (light_out == PAT_OFF) state_nxt = S_IDLE;
        else                           hit_err   = 1'b1;
      end
      S_R1: begin
        if (light_out == PAT_R2)       state_nxt = S_R2;
        else if (light_out == PAT_OFF) state_nxt = S_IDLE;
        else                           hit_err   = 1'b1;
      end
      S_R2: begin
        if (light_out == PAT_R3)       state_nxt = S_R3;
        else if (light_out == PAT_OFF) state_nxt = S_IDLE;
        else                           hit_err   = 1'b1;
      end
      S_L3, S_R3, S_HZ: begin
        if (light_out == PAT_OFF) begin
          state_nxt = S_IDLE;
          hit_done  = 1'b1;
        end else begin
          hit_err = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        hit_err   = 1'b1;
      end
    endcase
    if (hit_err) begin
      state_nxt = resync_state(light_out);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      mode     <= MODE_IDLE;
      step     <= 2'd0;
      seq_done <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= state_mode(state_nxt);
      step     <= state_step(state_nxt);
      seq_done <= hit_done;
      err      <= hit_err;
    end
  end

  tb_sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hit_err),
    .q     (err_count)
  );

`ifdef THUNDERBIRD_DEC_STAT_EN
  logic done_left;
  logic done_right;
  logic done_hz;

  assign done_left  = hit_done && (state == S_L3);
  assign done_right = hit_done && (state == S_R3);
  assign done_hz    = hit_done && (state == S_HZ);

  tb_sat_counter #(.W(CNT_W)) u_left_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (done_left),
    .q     (left_cnt)
  );

  tb_sat_counter #(.W(CNT_W)) u_right_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (done_right),
    .q     (right_cnt)
  );

  tb_sat_counter #(.W(CNT_W)) u_hz_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (done_hz),
    .q     (hz_cnt)
  );
`else
  assign left_cnt  = '0;
  assign right_cnt = '0;
  assign hz_cnt    = '0;
`endif

endmodule

// File: tb/tb_thunderbird_light_decoder.sv
// Scoreboard bench for thunderbird_light_decoder: directed lamp-bus vectors with
// hand-computed expectations; a monitor pops and compares one entry per cycle.
module tb_thunderbird_light_decoder;

  localparam int CNT_W = 8;

  localparam logic [5:0] OFF = 6'b000000;
  localparam logic [5:0] L1  = 6'b001000;
  localparam logic [5:0] L2  = 6'b011000;
  localparam logic [5:0] L3  = 6'b111000;
  localparam logic [5:0] R1  = 6'b000100;
  localparam logic [5:0] R2  = 6'b000110;
  localparam logic [5:0] R3  = 6'b000111;
  localparam logic [5:0] ALL = 6'b111111;
  localparam logic [5:0] BAD = 6'b010010;

  localparam int D_NONE  = 0;
  localparam int D_LEFT  = 1;
  localparam int D_RIGHT = 2;
  localparam int D_HZ    = 3;

  logic             clk;
  logic             reset;
  logic [5:0]       light_out;
  logic [1:0]       mode;
  logic [1:0]       step;
  logic             seq_done;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] left_cnt;
  logic [CNT_W-1:0] right_cnt;
  logic [CNT_W-1:0] hz_cnt;

  thunderbird_light_decoder #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .light_out (light_out),
    .mode      (mode),
    .step      (step),
    .seq_done  (seq_done),
    .err       (err),
    .err_count (err_count),
    .left_cnt  (left_cnt),
    .right_cnt (right_cnt),
    .hz_cnt    (hz_cnt)
  );

  typedef struct {
    logic [1:0]       mode;
    logic [1:0]       step;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] ec;
    logic [CNT_W-1:0] lc;
    logic [CNT_W-1:0] rc;
    logic [CNT_W-1:0] hc;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  int exp_err   = 0;
  int exp_left  = 0;
  int exp_right = 0;
  int exp_hz    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Drive one pattern for exactly one sampling edge and queue the expectation.
  task automatic drive(input logic [5:0] pat, input logic [1:0] m, input logic [1:0] s,
                       input int done_kind, input logic e);
    exp_t x;
    @(negedge clk);
    light_out = pat;
    @(posedge clk);
    if (e) exp_err = sat_inc(exp_err);
    if (done_kind == D_LEFT)  exp_left  = sat_inc(exp_left);
    if (done_kind == D_RIGHT) exp_right = sat_inc(exp_right);
    if (done_kind == D_HZ)    exp_hz    = sat_inc(exp_hz);
    x.mode = m;
    x.step = s;
    x.done = (done_kind != D_NONE);
    x.err  = e;
    x.ec   = CNT_W'(exp_err);
`ifdef THUNDERBIRD_DEC_STAT_EN
    x.lc   = CNT_W'(exp_left);
    x.rc   = CNT_W'(exp_right);
    x.hc   = CNT_W'(exp_hz);
`else
    x.lc   = '0;
    x.rc   = '0;
    x.hc   = '0;
`endif
    sb.push_back(x);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mode"},      int'(mode),      0);
    check({tag, ".step"},      int'(step),      0);
    check({tag, ".seq_done"},  int'(seq_done),  0);
    check({tag, ".err"},       int'(err),       0);
    check({tag, ".err_count"}, int'(err_count), 0);
    check({tag, ".left_cnt"},  int'(left_cnt),  0);
    check({tag, ".right_cnt"}, int'(right_cnt), 0);
    check({tag, ".hz_cnt"},    int'(hz_cnt),    0);
  endtask

  // Monitor: one registered response per sampled pattern, compared mid-cycle.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check("mode",      int'(mode),      int'(x.mode));
        check("step",      int'(step),      int'(x.step));
        check("seq_done",  int'(seq_done),  int'(x.done));
        check("err",       int'(err),       int'(x.err));
        check("err_count", int'(err_count), int'(x.ec));
        check("left_cnt",  int'(left_cnt),  int'(x.lc));
        check("right_cnt", int'(right_cnt), int'(x.rc));
        check("hz_cnt",    int'(hz_cnt),    int'(x.hc));
      end
    end
  end

  initial begin
    reset     = 1'b0;
    light_out = OFF;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    // idle
    drive(OFF, 2'd0, 2'd0, D_NONE, 1'b0);

    // left sequence
    drive(L1,  2'd1, 2'd1, D_NONE, 1'b0);
    drive(L2,  2'd1, 2'd2, D_NONE, 1'b0);
    drive(L3,  2'd1, 2'd3, D_NONE, 1'b0);
    drive(OFF, 2'd0, 2'd0, D_LEFT, 1'b0);

    // right sequence twice, back to back
    for (int i = 0; i < 2; i++) begin
      drive(R1,  2'd2, 2'd1, D_NONE,  1'b0);
      drive(R2,  2'd2, 2'd2, D_NONE,  1'b0);
      drive(R3,  2'd2, 2'd3, D_NONE,  1'b0);
      drive(OFF, 2'd0, 2'd0, D_RIGHT, 1'b0);
    end

    // hazard: ALL/OFF alternating for 10 clocks
    for (int i = 0; i < 5; i++) begin
      drive(ALL, 2'd3, 2'd1, D_NONE, 1'b0);
      drive(OFF, 2'd0, 2'd0, D_HZ,   1'b0);
    end

    // errors and resync
    drive(L1,  2'd1, 2'd1, D_NONE, 1'b0);
    drive(L3,  2'd0, 2'd0, D_NONE, 1'b1);  // skipped L2
    drive(L1,  2'd1, 2'd1, D_NONE, 1'b0);
    drive(OFF, 2'd0, 2'd0, D_NONE, 1'b0);  // abort
    drive(BAD, 2'd0, 2'd0, D_NONE, 1'b1);  // illegal from idle
    drive(L1,  2'd1, 2'd1, D_NONE, 1'b0);
    drive(L1,  2'd1, 2'd1, D_NONE, 1'b1);  // held L1, resync to S_L1
    drive(L2,  2'd1, 2'd2, D_NONE, 1'b0);
    drive(R1,  2'd2, 2'd1, D_NONE, 1'b1);  // wrong direction, resync to S_R1
    drive(OFF, 2'd0, 2'd0, D_NONE, 1'b0);  // abort
    drive(ALL, 2'd3, 2'd1, D_NONE, 1'b0);
    drive(ALL, 2'd3, 2'd1, D_NONE, 1'b1);  // held ALL, resync to S_HZ
    drive(OFF, 2'd0, 2'd0, D_HZ,   1'b0);

    // abort of a right sequence
    drive(R1,  2'd2, 2'd1, D_NONE, 1'b0);
    drive(R2,  2'd2, 2'd2, D_NONE, 1'b0);
    drive(OFF, 2'd0, 2'd0, D_NONE, 1'b0);

    // async reset in S_L2
    drive(L1,  2'd1, 2'd1, D_NONE, 1'b0);
    drive(L2,  2'd1, 2'd2, D_NONE, 1'b0);
    @(negedge clk);
    #2;
    light_out = OFF;
    reset     = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_err   = 0;
    exp_left  = 0;
    exp_right = 0;
    exp_hz    = 0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset.seq_done_held", int'(seq_done), 0);
    check("midreset.err_held",      int'(err),      0);
    @(negedge clk);
    reset = 1'b1;
    drive(OFF, 2'd0, 2'd0, D_NONE, 1'b0);

    // saturation of err_count
    for (int i = 0; i < 300; i++) begin
      drive(BAD, 2'd0, 2'd0, D_NONE, 1'b1);
    end
    drive(OFF, 2'd0, 2'd0, D_NONE, 1'b0);
    check("sat.model_err", exp_err, 255);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard.leftover", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
